r4_quo_otfc: RTL and testbench

Radix-4 on-the-fly conversion (OTFC) and iteration controller for the scalar SRT divider. It consumes one redundant quotient digit in {-2,-1,0,+1,+2} per iteration from the radix-4 QDS, one-hot encoded, and keeps two registers in parallel: Q, the quotient, and QM, equal to Q-1. After the last digit it uses the final remainder sign to pick the correctly rounded-down quotient, then returns it over a valid/ready handshake. It sits between the QDS/remainder datapath and the divider post-processing stage.

---
 rtl/r4_div_pkg.sv | 18 +
 rtl/r4_quo_otfc_if.sv | 27 ++
 rtl/r4_otfc_step.sv | 42 ++++
 rtl/r4_quo_otfc.sv | 91 +++++++++
 tb/tb_r4_quo_otfc.sv | 230 +++++++++++++++++++++++
 5 files changed

// File: rtl/r4_div_pkg.sv
// Shared encodings for the radix-4 SRT divider: quotient digit bit positions,
// converter FSM states and the OTFC append patterns.
package r4_div_pkg;

  localparam int QDIG_NEG2 = 4;
  localparam int QDIG_NEG1 = 3;
  localparam int QDIG_ZERO = 2;
  localparam int QDIG_POS1 = 1;
  localparam int QDIG_POS2 = 0;

  typedef enum logic [1:0] {IDLE, ITER, CORR, DONE} otfc_state_e;

  localparam logic [1:0] APP_10 = 2'b10;
  localparam logic [1:0] APP_01 = 2'b01;
  localparam logic [1:0] APP_00 = 2'b00;
  localparam logic [1:0] APP_11 = 2'b11;

endpackage

// File: rtl/r4_quo_otfc_if.sv
// Handshake bundle between the QDS/remainder datapath, the quotient converter
// and the post-processing stage.
interface r4_quo_otfc_if #(parameter int QUO_W = 56);
  localparam int CNT_W = $clog2(QUO_W/2) + 1;

  logic             start_valid_i;
  logic             start_ready_o;
  logic [CNT_W-1:0] iter_num_i;
  logic             quo_dig_valid_i;
  logic             quo_dig_ready_o;
  logic [4:0]       quo_dig_i;
  logic             rem_sign_i;
  logic             finish_valid_o;
  logic             finish_ready_i;
  logic [QUO_W-1:0] quo_o;
  logic             err_o;

  modport master (
    output start_valid_i, iter_num_i, quo_dig_valid_i, quo_dig_i, rem_sign_i, finish_ready_i,
    input  start_ready_o, quo_dig_ready_o, finish_valid_o, quo_o, err_o
  );

  modport slave (
    input  start_valid_i, iter_num_i, quo_dig_valid_i, quo_dig_i, rem_sign_i, finish_ready_i,
    output start_ready_o, quo_dig_ready_o, finish_valid_o, quo_o, err_o
  );
endinterface

// File: rtl/r4_otfc_step.sv
// One radix-4 on-the-fly conversion step: next Q / QM (=Q-1) for one digit.
// Purely combinational so it can be chained for multi-digit-per-cycle variants.
module r4_otfc_step
  import r4_div_pkg::*;
#(
  parameter int QUO_W = 56
) (
  input  logic [QUO_W-1:0] q,
  input  logic [QUO_W-1:0] qm,
  input  logic [4:0]       dig,
  output logic [QUO_W-1:0] q_nx,
  output logic [QUO_W-1:0] qm_nx,
  output logic             invalid
);

  // Shift left by one digit (top 2 bits drop out) and append a pattern.
  function automatic logic [QUO_W-1:0] app(input logic [QUO_W-1:0] base, input logic [1:0] a);
    return (base << 2) | {{(QUO_W-2){1'b0}}, a};
  endfunction

  always_comb begin
    invalid = 1'b0;
    q_nx    = app(q,  APP_00);
    qm_nx   = app(qm, APP_11);
    if (!$onehot(dig)) begin
      invalid = 1'b1;
    end else if (dig[QDIG_POS2]) begin
      q_nx  = app(q, APP_10);
      qm_nx = app(q, APP_01);
    end else if (dig[QDIG_POS1]) begin
      q_nx  = app(q, APP_01);
      qm_nx = app(q, APP_00);
    end else if (dig[QDIG_NEG1]) begin
      q_nx  = app(qm, APP_11);
      qm_nx = app(qm, APP_10);
    end else if (dig[QDIG_NEG2]) begin
      q_nx  = app(qm, APP_10);
      qm_nx = app(qm, APP_01);
    end
  end

endmodule

// File: rtl/r4_quo_otfc.sv
// Radix-4 quotient OTFC plus iteration controller: accepts N digits, applies
// the remainder-sign correction, and hands the quotient downstream.
module r4_quo_otfc
  import r4_div_pkg::*;
#(
  parameter int QUO_W = 56
) (
  input  logic         clk,
  input  logic         rst_n,
  r4_quo_otfc_if.slave bus
);

  localparam int               CNT_W    = $clog2(QUO_W/2) + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(QUO_W/2);

  otfc_state_e      state, state_nx;
  logic [QUO_W-1:0] q, qm, q_nx, qm_nx, quo;
  logic [CNT_W-1:0] cnt, cnt_ld;
  logic             err, err_q, dig_inv;
  logic             start_fire, dig_fire;
  logic             start_rdy, dig_rdy, fin_vld;

  assign start_fire = bus.start_valid_i && (state == IDLE);
  assign dig_fire   = bus.quo_dig_valid_i && (state == ITER);
  // Zero or out-of-range counts fall back to a full-width conversion.
  assign cnt_ld     = (bus.iter_num_i == '0 || bus.iter_num_i > FULL_CNT) ? FULL_CNT
                                                                           : bus.iter_num_i;

  r4_otfc_step #(.QUO_W(QUO_W)) u_step (
    .q       (q),
    .qm      (qm),
    .dig     (bus.quo_dig_i),
    .q_nx    (q_nx),
    .qm_nx   (qm_nx),
    .invalid (dig_inv)
  );

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (bus.start_valid_i) state_nx = ITER;
      ITER: if (dig_fire && cnt == CNT_W'(1)) state_nx = CORR;
      CORR: state_nx = DONE;
      DONE: if (bus.finish_ready_i) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      q         <= '0;
      qm        <= '1;
      cnt       <= '0;
      err       <= 1'b0;
      err_q     <= 1'b0;
      quo       <= '0;
      start_rdy <= 1'b1;
      dig_rdy   <= 1'b0;
      fin_vld   <= 1'b0;
    end else begin
      state     <= state_nx;
      // Handshake flags are decoded from the next state so they leave a flop.
      start_rdy <= (state_nx == IDLE);
      dig_rdy   <= (state_nx == ITER);
      fin_vld   <= (state_nx == DONE);
      if (start_fire) begin
        q   <= '0;
        qm  <= '1;
        cnt <= cnt_ld;
        err <= 1'b0;
      end else if (dig_fire) begin
        q   <= q_nx;
        qm  <= qm_nx;
        cnt <= cnt - CNT_W'(1);
        err <= err | dig_inv;
      end
      if (state == CORR) begin
        quo   <= bus.rem_sign_i ? qm : q;
        err_q <= err;
      end
    end
  end

  assign bus.start_ready_o   = start_rdy;
  assign bus.quo_dig_ready_o = dig_rdy;
  assign bus.finish_valid_o  = fin_vld;
  assign bus.quo_o           = quo;
  assign bus.err_o           = err_q;

endmodule

// File: tb/tb_r4_quo_otfc.sv
// Bench for r4_quo_otfc at QUO_W=8: directed digit strings, stalls, invalid
// digits, mid-run reset and random runs against an integer quotient model.
module tb_r4_quo_otfc;
  localparam int W  = 8;
  localparam int CW = $clog2(W/2) + 1;

  localparam logic [4:0] DP2 = 5'b00001;
  localparam logic [4:0] DP1 = 5'b00010;
  localparam logic [4:0] DZ  = 5'b00100;
  localparam logic [4:0] DM1 = 5'b01000;
  localparam logic [4:0] DM2 = 5'b10000;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  r4_quo_otfc_if #(.QUO_W(W)) bus ();
  r4_quo_otfc #(.QUO_W(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int n_chk = 0;
  int n_fail = 0;
  logic [4:0] dq[$];

  logic [W-1:0] r_quo;
  logic r_err, r_ok, r_ign, r_stable, r_idle, r_rdy1;
  int r_lat;

  function automatic int eff_n(input int itn);
    return (itn == 0 || itn > W/2) ? W/2 : itn;
  endfunction

  // Quotient value = sum of digits * 4^k, modulo 2^W, minus one if remainder negative.
  function automatic logic [W-1:0] ref_quo(input int itn, input logic rs, output logic e);
    longint v;
    v = 0;
    e = 1'b0;
    for (int i = 0; i < eff_n(itn); i++) begin
      case (dq[i])
        DP2: v = v * 4 + 2;
        DP1: v = v * 4 + 1;
        DZ:  v = v * 4;
        DM1: v = v * 4 - 1;
        DM2: v = v * 4 - 2;
        default: begin v = v * 4; e = 1'b1; end
      endcase
    end
    return W'(v - longint'(rs));
  endfunction

  function automatic logic [4:0] rnd_dig(input int pct_bad);
    logic [4:0] d;
    if (int'($urandom_range(99, 0)) < pct_bad) d = 5'($urandom);
    else d = 5'b00001 << $urandom_range(4, 0);
    return d;
  endfunction

  // Drives one full conversion; results land in the r_* variables.
  task automatic do_run(input int itn, input logic rs, input int max_gap,
                        input int fin_wait, input logic poke);
    int n, cyc, k, g;
    n = eff_n(itn);
    r_ok = 1'b1; r_ign = 1'b1; r_stable = 1'b1;
    bus.rem_sign_i = rs;
    bus.iter_num_i = CW'(itn);
    bus.start_valid_i = 1'b1;
    k = 0;
    while (!bus.start_ready_o && k < 20) begin @(posedge clk); #1; k++; end
    if (!bus.start_ready_o) r_ok = 1'b0;
    @(posedge clk); #1;
    bus.start_valid_i = 1'b0;
    cyc = 1;
    r_rdy1 = bus.quo_dig_ready_o;
    for (int i = 0; i < n; i++) begin
      g = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
      for (int j = 0; j < g; j++) begin
        bus.quo_dig_i = 5'($urandom);
        if (poke) bus.start_valid_i = 1'b1;
        if (bus.start_ready_o) r_ign = 1'b0;
        @(posedge clk); #1; cyc++;
        bus.start_valid_i = 1'b0;
      end
      bus.quo_dig_valid_i = 1'b1;
      bus.quo_dig_i = dq[i];
      @(posedge clk); #1; cyc++;
      bus.quo_dig_valid_i = 1'b0;
      bus.quo_dig_i = 5'($urandom);
    end
    k = 0;
    while (!bus.finish_valid_o && k < 10) begin @(posedge clk); #1; cyc++; k++; end
    if (!bus.finish_valid_o) r_ok = 1'b0;
    r_lat = cyc;
    r_quo = bus.quo_o;
    r_err = bus.err_o;
    for (int j = 0; j < fin_wait; j++) begin
      if (poke) bus.start_valid_i = 1'b1;
      @(posedge clk); #1;
      bus.start_valid_i = 1'b0;
      if (bus.quo_o !== r_quo || bus.err_o !== r_err || !bus.finish_valid_o) r_stable = 1'b0;
      if (bus.start_ready_o) r_ign = 1'b0;
    end
    bus.finish_ready_i = 1'b1;
    @(posedge clk); #1;
    bus.finish_ready_i = 1'b0;
    r_idle = bus.start_ready_o && !bus.finish_valid_o;
  endtask

  task automatic test_reset();
    n_chk++; if (bus.start_ready_o !== 1'b1) begin n_fail++; $display("FAIL reset start_ready: got %b want 1", bus.start_ready_o); end
    n_chk++; if (bus.quo_dig_ready_o !== 1'b0) begin n_fail++; $display("FAIL reset dig_ready: got %b want 0", bus.quo_dig_ready_o); end
    n_chk++; if (bus.finish_valid_o !== 1'b0) begin n_fail++; $display("FAIL reset finish_valid: got %b want 0", bus.finish_valid_o); end
    n_chk++; if (bus.quo_o !== '0) begin n_fail++; $display("FAIL reset quo: got %h want 00", bus.quo_o); end
    n_chk++; if (bus.err_o !== 1'b0) begin n_fail++; $display("FAIL reset err: got %b want 0", bus.err_o); end
  endtask

  task automatic test_directed();
    dq = '{DP2, DP2, DP2, DP2};
    do_run(4, 1'b0, 0, 0, 1'b0);
    n_chk++; if (!r_ok) begin n_fail++; $display("FAIL dir_p2 timeout"); end
    n_chk++; if (r_quo !== 8'hAA) begin n_fail++; $display("FAIL dir_p2 quo: got %h want aa", r_quo); end
    n_chk++; if (r_err !== 1'b0) begin n_fail++; $display("FAIL dir_p2 err: got %b want 0", r_err); end
    n_chk++; if (r_lat != 6) begin n_fail++; $display("FAIL dir_p2 latency: got %0d want 6", r_lat); end
    n_chk++; if (r_rdy1 !== 1'b1) begin n_fail++; $display("FAIL dir_p2 dig_ready at t+1: got %b want 1", r_rdy1); end
    n_chk++; if (r_idle !== 1'b1) begin n_fail++; $display("FAIL dir_p2 idle after finish: got %b want 1", r_idle); end
    dq = '{DP1, DM1};
    do_run(2, 1'b0, 0, 0, 1'b0);
    n_chk++; if (r_quo !== 8'h03) begin n_fail++; $display("FAIL dir_pm rs0 quo: got %h want 03", r_quo); end
    do_run(2, 1'b1, 0, 0, 1'b0);
    n_chk++; if (r_quo !== 8'h02) begin n_fail++; $display("FAIL dir_pm rs1 quo: got %h want 02", r_quo); end
    n_chk++; if (r_lat != 4) begin n_fail++; $display("FAIL dir_pm latency: got %0d want 4", r_lat); end
    dq = '{DZ, DZ};
    do_run(2, 1'b1, 0, 0, 1'b0);
    n_chk++; if (r_quo !== 8'hFF) begin n_fail++; $display("FAIL dir_zz quo: got %h want ff", r_quo); end
  endtask

  task automatic test_stall();
    logic [W-1:0] exp_q;
    logic exp_e, rs;
    dq.delete();
    for (int i = 0; i < 4; i++) dq.push_back(rnd_dig(0));
    rs = 1'($urandom);
    exp_q = ref_quo(4, rs, exp_e);
    do_run(4, rs, 3, 3, 1'b1);
    n_chk++; if (!r_ok) begin n_fail++; $display("FAIL stall timeout"); end
    n_chk++; if (r_quo !== exp_q) begin n_fail++; $display("FAIL stall quo: got %h want %h", r_quo, exp_q); end
    n_chk++; if (r_stable !== 1'b1) begin n_fail++; $display("FAIL stall held outputs: got %b want 1", r_stable); end
    n_chk++; if (r_ign !== 1'b1) begin n_fail++; $display("FAIL stall start ignored: got %b want 1", r_ign); end
    n_chk++; if (r_idle !== 1'b1) begin n_fail++; $display("FAIL stall idle after finish: got %b want 1", r_idle); end
  endtask

  task automatic test_err();
    dq = '{DP1, 5'b00011, DP1, DP2};
    do_run(4, 1'b0, 1, 0, 1'b0);
    n_chk++; if (r_err !== 1'b1) begin n_fail++; $display("FAIL err set: got %b want 1", r_err); end
    n_chk++; if (r_quo !== 8'h46) begin n_fail++; $display("FAIL err quo: got %h want 46", r_quo); end
    dq = '{DP1, DZ, DP1, DP2};
    do_run(4, 1'b0, 0, 0, 1'b0);
    n_chk++; if (r_err !== 1'b0) begin n_fail++; $display("FAIL err cleared: got %b want 0", r_err); end
    n_chk++; if (r_quo !== 8'h46) begin n_fail++; $display("FAIL err rerun quo: got %h want 46", r_quo); end
  endtask

  task automatic test_reset_mid();
    logic [W-1:0] exp_q;
    logic exp_e;
    bus.iter_num_i = CW'(4);
    bus.start_valid_i = 1'b1;
    @(posedge clk); #1;
    bus.start_valid_i = 1'b0;
    for (int i = 0; i < 2; i++) begin
      bus.quo_dig_valid_i = 1'b1; bus.quo_dig_i = DM2;
      @(posedge clk); #1;
    end
    bus.quo_dig_valid_i = 1'b0;
    n_chk++; if (bus.quo_dig_ready_o !== 1'b1) begin n_fail++; $display("FAIL rstmid in ITER: got %b want 1", bus.quo_dig_ready_o); end
    #1 rst_n = 1'b0;
    #1;
    n_chk++; if (bus.start_ready_o !== 1'b1 || bus.quo_dig_ready_o !== 1'b0 || bus.finish_valid_o !== 1'b0)
      begin n_fail++; $display("FAIL rstmid handshake: got sr=%b dr=%b fv=%b want 1 0 0", bus.start_ready_o, bus.quo_dig_ready_o, bus.finish_valid_o); end
    n_chk++; if (bus.quo_o !== '0 || bus.err_o !== 1'b0) begin n_fail++; $display("FAIL rstmid data: got %h/%b want 00/0", bus.quo_o, bus.err_o); end
    @(posedge clk); #1 rst_n = 1'b1;
    dq = '{DP1, DM2, DZ, DP2};
    exp_q = ref_quo(4, 1'b1, exp_e);
    do_run(4, 1'b1, 0, 0, 1'b0);
    n_chk++; if (r_quo !== exp_q) begin n_fail++; $display("FAIL rstmid rerun quo: got %h want %h", r_quo, exp_q); end
  endtask

  task automatic test_random();
    logic [W-1:0] exp_q;
    logic exp_e, rs;
    int itn;
    for (int r = 0; r < 20; r++) begin
      itn = $urandom_range(7, 0);
      rs = 1'($urandom);
      dq.delete();
      for (int i = 0; i < 4; i++) dq.push_back(rnd_dig(15));
      exp_q = ref_quo(itn, rs, exp_e);
      do_run(itn, rs, 2, $urandom_range(2, 0), 1'b1);
      n_chk++; if (!r_ok || r_quo !== exp_q) begin n_fail++; $display("FAIL rand[%0d] quo n=%0d: got %h want %h", r, itn, r_quo, exp_q); end
      n_chk++; if (r_err !== exp_e) begin n_fail++; $display("FAIL rand[%0d] err: got %b want %b", r, r_err, exp_e); end
    end
  endtask

  initial begin
    rst_n = 1'b1;
    bus.start_valid_i = 1'b0;
    bus.iter_num_i = '0;
    bus.quo_dig_valid_i = 1'b0;
    bus.quo_dig_i = '0;
    bus.rem_sign_i = 1'b0;
    bus.finish_ready_i = 1'b0;
    #2 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    rst_n = 1'b1;
    @(posedge clk); #1;
    test_directed();
    test_stall();
    test_err();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
